// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if: request/grant/result bundle for the shared BCD converter.
// master = requester side (req, val_in out); slave = converter side.
interface bcd_conv_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] val_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (
    output req, val_in,
    input  gnt, busy, done, bcd_out, ovf
  );

  modport slave (
    input  req, val_in,
    output gnt, busy, done, bcd_out, ovf
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin shared shift-and-add-3 binary-to-BCD converter.
// Ports: clk, rst (async, active-high), bus (slave: req/val_in in; gnt/busy/done/bcd_out/ovf out).
// Optional: define BCD_BLANK_LEAD_EN to blank leading zero digits with 4'hF.
module bcd_conv_arbiter #(
  parameter int NREQ   = 2,
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  bcd_conv_arbiter_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int AW = BW + 4;
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0] MAXV = pow10(DIGITS) - 32'd1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, nstate;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic             any;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] sh;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_adj;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic [BW-1:0]    bcd_q;
  logic             ovf_o;
  logic [BW-1:0]    bcd_fmt;

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_o;
  assign bus.busy    = (state != IDLE);

  // Search starts one past the last winner and wraps.
  always_comb begin
    win = ptr;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && bus.req[(int'(ptr) + k) % NREQ]) begin
        any = 1'b1;
        win = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign opnd = bus.val_in[int'(win)*WIDTH +: WIDTH];

  // Top digit included so the spare nibble absorbs any carry.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d <= DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5)
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

`ifdef BCD_BLANK_LEAD_EN
  logic lead;
  always_comb begin
    bcd_fmt = acc[BW-1:0];
    lead    = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && bcd_fmt[4*i +: 4] == 4'd0)
        bcd_fmt[4*i +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  end
`else
  always_comb begin
    bcd_fmt = acc[BW-1:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (any) nstate = SHIFT;
      SHIFT:   if (cnt == '0) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= PW'(NREQ - 1);
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      gnt_q  <= '0;
      done_q <= '0;
      bcd_q  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt_q <= NREQ'(1) << win;
            ptr   <= win;
            sh    <= opnd;
            acc   <= '0;
            cnt   <= CW'(WIDTH - 1);
            ovf_q <= ({{(32-WIDTH){1'b0}}, opnd} > MAXV);
          end
        end
        SHIFT: begin
          acc <= {acc_adj[AW-2:0], sh[WIDTH-1]};
          sh  <= {sh[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
        end
        DONE: begin
          done_q <= NREQ'(1) << ptr;
          bcd_q  <= ovf_q ? {DIGITS{4'h9}} : bcd_fmt;
          ovf_o  <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed and random checks of the shared BCD converter.
// Drives the interface master side; expectations come from arithmetic in the bench.
module tb_bcd_conv_arbiter;

  localparam int NREQ   = 2;
  localparam int WIDTH  = 14;
  localparam int DIGITS = 4;

`ifdef BCD_BLANK_LEAD_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS)
  ) bus ();

  bcd_conv_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int last   = NREQ - 1;

  task automatic check(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    bit lead;
    if (v > 9999) return 16'h9999;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (BL) begin
      lead = 1'b1;
      for (int i = 3; i > 0; i--) begin
        if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    bus.val_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last = NREQ - 1;
  endtask

  task automatic set_req(input int i, input int unsigned v);
    bus.val_in[i*WIDTH +: WIDTH] = WIDTH'(v);
    bus.req[i] = 1'b1;
  endtask

  // Called at a negedge with requests already driven.
  task automatic serve(input int w, input logic [15:0] eb, input logic eo,
                       input bit drop, input string tag);
    int cyc;
    bit seen;
    bit extra;
    cyc = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != '0) seen = 1'b1;
    end
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(1) << w);
    check({tag, "_gnt_lat"}, cyc, 1);
    check({tag, "_busy"}, 32'(bus.busy), 1);
    last = w;
    if (drop) bus.req[w] = 1'b0;
    seen = 1'b0;
    extra = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.done != '0) seen = 1'b1;
      else if (bus.gnt != '0) extra = 1'b1;
    end
    check({tag, "_done"}, 32'(bus.done), 32'(1) << w);
    check({tag, "_lat"}, cyc - 1, WIDTH + 1);
    check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(eb));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, "_nogap"}, 32'(extra), 0);
  endtask

  initial begin
    int unsigned v [NREQ];
    logic [NREQ-1:0] m;
    int w;
    bit seen;
    bus.req = '0;
    bus.val_in = '0;

    apply_reset();
    #1;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_bcd", 32'(bus.bcd_out), 0);
    check("rst_ovf", 32'(bus.ovf), 0);

    set_req(0, 1234);
    serve(0, 16'h1234, 1'b0, 1'b1, "single");
    @(negedge clk);
    check("single_pulse", 32'(bus.done), 0);
    check("single_hold", 32'(bus.bcd_out), 32'h1234);

    apply_reset();
    set_req(0, 7);
    set_req(1, 9999);
    serve(0, BL ? 16'hFFF7 : 16'h0007, 1'b0, 1'b1, "arb0");
    serve(1, 16'h9999, 1'b0, 1'b1, "arb1");

    apply_reset();
    set_req(0, 100);
    set_req(1, 200);
    for (int n = 0; n < 4; n++)
      serve(n % 2, ref_bcd((n % 2) ? 200 : 100), 1'b0, 1'b0, "alt");
    bus.req = '0;

    set_req(0, 0);
    serve(0, BL ? 16'hFFF0 : 16'h0000, 1'b0, 1'b1, "v0");
    set_req(1, 9);
    serve(1, BL ? 16'hFFF9 : 16'h0009, 1'b0, 1'b1, "v9");
    set_req(0, 10);
    serve(0, BL ? 16'hFF10 : 16'h0010, 1'b0, 1'b1, "v10");
    set_req(1, 9999);
    serve(1, 16'h9999, 1'b0, 1'b1, "v9999");
    set_req(0, 10000);
    serve(0, 16'h9999, 1'b1, 1'b1, "v10000");
    set_req(1, 16383);
    serve(1, 16'h9999, 1'b1, 1'b1, "v16383");
    set_req(0, 5);
    serve(0, BL ? 16'hFFF5 : 16'h0005, 1'b0, 1'b1, "v5");

`ifdef BCD_BLANK_LEAD_EN
    set_req(1, 42);
    serve(1, 16'hFF42, 1'b0, 1'b1, "bl42");
    set_req(0, 1000);
    serve(0, 16'h1000, 1'b0, 1'b1, "bl1000");
`endif

    set_req(0, 4321);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) seen = 1'b1;
    end
    check("mid_gnt", 32'(bus.gnt), 1);
    bus.req = '0;
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("mid_bcd", 32'(bus.bcd_out), 0);
    check("mid_ovf", 32'(bus.ovf), 0);
    check("mid_busy0", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    last = NREQ - 1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done != '0) seen = 1'b1;
    end
    check("mid_nodone", 32'(seen), 0);
    set_req(0, 321);
    serve(0, BL ? 16'hF321 : 16'h0321, 1'b0, 1'b1, "after_rst");

    for (int it = 0; it < 8; it++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: v[i] = 0;
            1: v[i] = 9999;
            2: v[i] = 10000;
            default: v[i] = 16383;
          endcase
        end else begin
          v[i] = $urandom_range(0, 16383);
        end
        if (m[i]) set_req(i, v[i]);
      end
      while (m != '0) begin
        w = pick(m);
        serve(w, ref_bcd(v[w]), v[w] > 9999, 1'b1, "rnd");
        m[w] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
